// File: rtl/multi_chan_seq_gen.sv
// ---------------------------------------------------------------------------
// multi_chan_seq_gen : CH independent a/b/c sequencers with programmable busy
// length, sticky protocol-error flags and an aggregate busy count.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multi_chan_seq_gen #(
  parameter int CH        = 4,
  parameter int LEN_W     = 4,
  parameter bit DONE_HOLD = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CH-1:0]            a,
  input  logic [CH*LEN_W-1:0]      len,
  input  logic [CH-1:0]            ack,
  input  logic                     err_clr,
  output logic [CH-1:0]            b,
  output logic [CH-1:0]            c,
  output logic [CH-1:0]            err,
  output logic [$clog2(CH+1)-1:0]  busy_cnt
);

  localparam int CNT_W = $clog2(CH+1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q [CH];
  state_t           state_d [CH];
  logic [LEN_W-1:0] cnt_q   [CH];
  logic [LEN_W-1:0] cnt_d   [CH];
  logic [CH-1:0]    b_q, b_d;
  logic [CH-1:0]    c_q, c_d;
  logic [CH-1:0]    err_q, err_d;
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;

  always_comb begin
    busy_cnt_d = '0;
    b_d        = '0;
    c_d        = '0;
    err_d      = '0;
    for (int i = 0; i < CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      // A new violation in the same cycle as err_clr wins over the clear.
      err_d[i]   = err_q[i] & ~err_clr;
      case (state_q[i])
        S_IDLE: begin
          if (a[i]) begin
            if (len[i*LEN_W +: LEN_W] != '0) begin
              state_d[i] = S_BUSY;
              cnt_d[i]   = len[i*LEN_W +: LEN_W];
            end else begin
              state_d[i] = S_DONE;
            end
          end
        end
        S_BUSY: begin
          if (a[i]) err_d[i] = 1'b1;
          cnt_d[i] = cnt_q[i] - LEN_W'(1);
          if (cnt_q[i] == LEN_W'(1)) state_d[i] = S_DONE;
        end
        S_DONE: begin
          if (a[i]) err_d[i] = 1'b1;
          if (!DONE_HOLD || ack[i]) state_d[i] = S_IDLE;
        end
        default: state_d[i] = S_IDLE;
      endcase
      b_d[i]     = (state_d[i] == S_BUSY);
      c_d[i]     = (state_d[i] == S_DONE);
      busy_cnt_d = busy_cnt_d + CNT_W'(b_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
      b_q        <= '0;
      c_q        <= '0;
      err_q      <= '0;
      busy_cnt_q <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      b_q        <= b_d;
      c_q        <= c_d;
      err_q      <= err_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign b        = b_q;
  assign c        = c_q;
  assign err      = err_q;
  assign busy_cnt = busy_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_chan_seq_gen.sv
// Directed bench for multi_chan_seq_gen: one pulse-mode and one hold-mode
// instance checked every cycle against spec-timed expectations and a c-event scoreboard.
`default_nettype none

module tb_multi_chan_seq_gen;

  localparam int CH    = 4;
  localparam int LEN_W = 4;
  localparam int CNT_W = $clog2(CH+1);
  localparam int NP    = 1024;

  logic                clk     = 1'b0;
  logic                rst_n   = 1'b0;
  logic                err_clr = 1'b0;
  logic [CH-1:0]       a0 = '0, a1 = '0, ack0 = '1, ack1 = '0;
  logic [CH*LEN_W-1:0] len0 = '0, len1 = '0;
  logic [CH-1:0]       b0, c0, err0, b1, c1, err1;
  logic [CNT_W-1:0]    cnt0, cnt1;

  always #5 clk = ~clk;

  multi_chan_seq_gen #(.CH(CH), .LEN_W(LEN_W), .DONE_HOLD(1'b0)) u_pulse (
    .clk(clk), .rst_n(rst_n), .a(a0), .len(len0), .ack(ack0), .err_clr(err_clr),
    .b(b0), .c(c0), .err(err0), .busy_cnt(cnt0)
  );

  multi_chan_seq_gen #(.CH(CH), .LEN_W(LEN_W), .DONE_HOLD(1'b1)) u_hold (
    .clk(clk), .rst_n(rst_n), .a(a1), .len(len1), .ack(ack1), .err_clr(err_clr),
    .b(b1), .c(c1), .err(err1), .busy_cnt(cnt1)
  );

  typedef struct {
    int inst;
    int ch;
    int p;
  } ev_t;

  ev_t           sb[$];
  logic [CH-1:0] exp_b0 [NP];
  logic [CH-1:0] exp_c0 [NP];
  logic [CH-1:0] exp_b1 [NP];
  logic [CH-1:0] exp_c1 [NP];
  logic [CH-1:0] ack_sched [NP];
  logic [CH-1:0] exp_err0 = '0, exp_err1 = '0;
  logic [CH-1:0] prev_c0 = '0, prev_c1 = '0;
  int            cyc   = 0;
  int            vec   = 0;
  int            fails = 0;
  int            k;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vec++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_sb(input int inst, input logic [CH-1:0] cv, input logic [CH-1:0] pc);
    for (int i = 0; i < CH; i++) begin
      if (cv[i] && !pc[i]) begin
        int idx;
        idx = -1;
        foreach (sb[j]) if (idx < 0 && sb[j].inst == inst && sb[j].ch == i) idx = j;
        chk($sformatf("c_expected i%0d ch%0d @%0d", inst, i, cyc), 32'(idx >= 0), 32'd1);
        if (idx >= 0) begin
          chk($sformatf("c_time i%0d ch%0d", inst, i), sb[idx].p, cyc);
          sb.delete(idx);
        end
      end
    end
  endtask

  task automatic check();
    chk($sformatf("b0@%0d", cyc),   32'(b0),   32'(exp_b0[cyc]));
    chk($sformatf("c0@%0d", cyc),   32'(c0),   32'(exp_c0[cyc]));
    chk($sformatf("cnt0@%0d", cyc), 32'(cnt0), $countones(exp_b0[cyc]));
    chk($sformatf("err0@%0d", cyc), 32'(err0), 32'(exp_err0));
    chk($sformatf("b1@%0d", cyc),   32'(b1),   32'(exp_b1[cyc]));
    chk($sformatf("c1@%0d", cyc),   32'(c1),   32'(exp_c1[cyc]));
    chk($sformatf("cnt1@%0d", cyc), 32'(cnt1), $countones(exp_b1[cyc]));
    chk($sformatf("err1@%0d", cyc), 32'(err1), 32'(exp_err1));
    check_sb(0, c0, prev_c0);
    check_sb(1, c1, prev_c1);
    prev_c0 = c0;
    prev_c1 = c1;
  endtask

  // Inputs set between ticks are sampled at the next posedge, then cleared.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    a0      = '0;
    a1      = '0;
    err_clr = 1'b0;
    @(negedge clk);
    check();
    ack1 = ack_sched[cyc];
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic run_until(input int p);
    while (cyc < p) tick();
  endtask

  // Start on the pulse instance: b visible for periods k..k+L-1, c in period k+L.
  task automatic go0(input int ch, input int l);
    int kk;
    ev_t e;
    kk = cyc + 1;
    for (int p = kk; p < kk + l; p++) exp_b0[p][ch] = 1'b1;
    exp_c0[kk+l][ch] = 1'b1;
    e.inst = 0; e.ch = ch; e.p = kk + l;
    sb.push_back(e);
    a0[ch] = 1'b1;
    len0[ch*LEN_W +: LEN_W] = LEN_W'(l);
  endtask

  // Start on the hold instance with c held for 'hold' periods before ack lands.
  task automatic go1(input int ch, input int l, input int hold);
    int kk;
    ev_t e;
    kk = cyc + 1;
    for (int p = kk; p < kk + l; p++) exp_b1[p][ch] = 1'b1;
    for (int p = kk + l; p < kk + l + hold; p++) exp_c1[p][ch] = 1'b1;
    ack_sched[kk+l+hold-1][ch] = 1'b1;
    e.inst = 1; e.ch = ch; e.p = kk + l;
    sb.push_back(e);
    a1[ch] = 1'b1;
    len1[ch*LEN_W +: LEN_W] = LEN_W'(l);
  endtask

  task automatic clear_future();
    for (int p = cyc; p < NP; p++) begin
      exp_b0[p] = '0; exp_c0[p] = '0;
      exp_b1[p] = '0; exp_c1[p] = '0;
      ack_sched[p] = '0;
    end
    sb.delete();
    exp_err0 = '0;
    exp_err1 = '0;
    prev_c0  = '0;
    prev_c1  = '0;
    ack1     = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int p = 0; p < NP; p++) begin
      exp_b0[p] = '0; exp_c0[p] = '0;
      exp_b1[p] = '0; exp_c1[p] = '0;
      ack_sched[p] = '0;
    end

    // Reset state held for a few cycles.
    run(3);
    rst_n = 1'b1;
    run(2);

    // len=3 on channel 0, ack ignored in pulse mode.
    go0(0, 3); tick(); run(6);

    // len=0 then the maximum length on channel 1.
    go0(1, 0); tick(); run(3);
    go0(1, 15); tick(); run(18);

    // Violations mid-BUSY and on the c cycle leave the sequence intact.
    go0(2, 5); tick(); k = cyc;
    a0[2] = 1'b1; exp_err0[2] = 1'b1; tick();
    run_until(k + 5);
    a0[2] = 1'b1; tick(); run(3);
    err_clr = 1'b1; exp_err0[2] = 1'b0; tick(); run(2);
    go0(2, 4); tick();
    a0[2] = 1'b1; err_clr = 1'b1; exp_err0[2] = 1'b1; tick(); run(6);
    err_clr = 1'b1; exp_err0[2] = 1'b0; tick(); run(1);
    go0(2, 1); tick(); tick();
    a0[2] = 1'b1; exp_err0[2] = 1'b1; tick(); run(2);
    err_clr = 1'b1; exp_err0[2] = 1'b0; tick(); run(1);

    // Earliest restart, one idle cycle after c falls.
    go0(3, 2); tick(); k = cyc;
    run_until(k + 3);
    go0(3, 2); tick(); run(5);

    // Hold mode: ack withheld for 5 c cycles, then ack on the first c cycle.
    go1(0, 2, 5); tick(); run(10);
    go1(0, 2, 1); tick(); run(5);
    go1(2, 0, 3); tick(); run(6);

    // All channels started together with lengths 1..4.
    for (int ch = 0; ch < CH; ch++) go0(ch, ch + 1);
    tick(); run(7);

    // Asynchronous reset mid-BUSY abandons both instances' sequences.
    go0(3, 10); go1(1, 10, 1); tick(); run(3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_b0",   32'(b0),   32'd0);
    chk("rst_c0",   32'(c0),   32'd0);
    chk("rst_cnt0", 32'(cnt0), 32'd0);
    chk("rst_b1",   32'(b1),   32'd0);
    chk("rst_cnt1", 32'(cnt1), 32'd0);
    clear_future();
    run(2);
    rst_n = 1'b1;
    run(15);

    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end

endmodule

`default_nettype wire
